// File: rtl/gates_bist_pkg.sv
// gates_bist_pkg
// Shared definitions for the Gates built-in self-test sequencer:
//   state_t    - sequencer states (IDLE, APPLY, DONE)
//   NUM_VEC    - number of truth-table vectors exercised per run
//   VEC_TABLE  - {A,B} stimulus for each vector index, idx0=00 .. idx3=11
//   ERR_W      - width of the failing-vector counter (holds 0..4)
package gates_bist_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int NUM_VEC = 4;
  localparam int ERR_W   = 3;

  typedef logic [ERR_W-1:0] err_t;

  // Entry i is the {A,B} pair driven while vector i is under test.
  localparam logic [NUM_VEC-1:0][1:0] VEC_TABLE = {2'b11, 2'b10, 2'b01, 2'b00};

endpackage

// File: rtl/gates_bist_if.sv
// gates_bist_if
// Bundles everything between the BIST sequencer and its surroundings except
// clk/rst: the run request and result summary, plus the stimulus/response
// link to the Gates block.
//   master : the BIST sequencer (drives A/B and status, samples Gates outputs)
//   slave  : the environment (Gates block and run controller)
interface gates_bist_if;
  import gates_bist_pkg::*;

  logic               start;
  logic               A;
  logic               B;
  logic               AND_in;
  logic               OR_in;
  logic               NOT_in;
  logic               busy;
  logic               done;
  logic               pass;
  err_t               err_count;
  logic [NUM_VEC-1:0] fail_vec;

  modport master (
    input  start, AND_in, OR_in, NOT_in,
    output A, B, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    output start, AND_in, OR_in, NOT_in,
    input  A, B, busy, done, pass, err_count, fail_vec
  );

endinterface

// File: rtl/gates_ref_model.sv
// gates_ref_model
// Combinational expected-value generator for the Gates block.
//   A, B    : stimulus currently applied to Gates
//   exp_and : expected AND output
//   exp_or  : expected OR output
//   exp_not : expected NOT output (NOT is taken on A only)
module gates_ref_model (
  input  logic A,
  input  logic B,
  output logic exp_and,
  output logic exp_or,
  output logic exp_not
);

  assign exp_and = A & B;
  assign exp_or  = A | B;
  assign exp_not = ~A;

endmodule

// File: rtl/gates_bist.sv
// gates_bist
// Self-test sequencer for the Gates block. On start it steps {A,B} through
// 00, 01, 10, 11, holding each vector HOLD_CYCLES cycles, then compares the
// Gates AND/OR/NOT outputs against the reference model in the last hold
// cycle. Failing vectors are flagged in fail_vec and counted in err_count;
// pass summarises the run once done is high.
// Ports:
//   clk             rising-edge clock
//   rst             synchronous, active-high reset
//   bus.start       one-cycle run request (ignored while busy)
//   bus.A/B         registered stimulus to Gates
//   bus.AND_in/OR_in/NOT_in  Gates responses
//   bus.busy        run in progress
//   bus.done        run finished, held until the next accepted start
//   bus.pass        1 when the finished run had no failing vectors
//   bus.err_count   number of failing vectors (0..4)
//   bus.fail_vec    bit i set when vector i failed
// Parameter HOLD_CYCLES: cycles per vector before sampling, legal 1..255.
module gates_bist
  import gates_bist_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  gates_bist_if.master bus
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [1:0] IDX_LAST  = 2'(NUM_VEC - 1);

  state_t             state_q, state_n;
  logic [1:0]         idx_q, idx_n, idx_inc;
  logic [7:0]         hold_q, hold_n;
  logic               a_q, a_n, b_q, b_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;
  logic               pass_q, pass_n;
  err_t               err_q, err_n;
  logic [NUM_VEC-1:0] fvec_q, fvec_n;

  logic exp_and, exp_or, exp_not;
  logic vec_fail;

  gates_ref_model u_ref (
    .A       (a_q),
    .B       (b_q),
    .exp_and (exp_and),
    .exp_or  (exp_or),
    .exp_not (exp_not)
  );

  // Comparison uses the registered stimulus, which has been stable for the
  // whole hold window by the time it is sampled.
  assign vec_fail = (bus.AND_in != exp_and) |
                    (bus.OR_in  != exp_or)  |
                    (bus.NOT_in != exp_not);

  assign idx_inc = idx_q + 2'd1;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold it.
    state_n = state_q;
    idx_n   = idx_q;
    hold_n  = hold_q;
    a_n     = a_q;
    b_n     = b_q;
    busy_n  = busy_q;
    done_n  = done_q;
    pass_n  = pass_q;
    err_n   = err_q;
    fvec_n  = fvec_q;

    case (state_q)
      // DONE restarts exactly like IDLE; start during APPLY is not decoded.
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_n    = S_APPLY;
          idx_n      = '0;
          hold_n     = '0;
          {a_n, b_n} = VEC_TABLE[0];
          busy_n     = 1'b1;
          done_n     = 1'b0;
          pass_n     = 1'b0;
          err_n      = '0;
          fvec_n     = '0;
        end
      end

      S_APPLY: begin
        hold_n = hold_q + 8'd1;
        if (hold_q == HOLD_LAST) begin
          if (vec_fail) begin
            fvec_n[idx_q] = 1'b1;
            err_n         = err_q + err_t'(1);
          end
          if (idx_q != IDX_LAST) begin
            idx_n      = idx_inc;
            {a_n, b_n} = VEC_TABLE[idx_inc];
            hold_n     = '0;
          end else begin
            // pass must include the last vector's verdict, hence err_n.
            state_n = S_DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            pass_n  = (err_n == '0);
          end
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: reset is sampled on the clock edge (synchronous); it overrides any
  // start in the same cycle and discards a partial run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fvec_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // same pre-edge values.
      state_q <= state_n;
      idx_q   <= idx_n;
      hold_q  <= hold_n;
      a_q     <= a_n;
      b_q     <= b_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      pass_q  <= pass_n;
      err_q   <= err_n;
      fvec_q  <= fvec_n;
    end
  end

  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_vec  = fvec_q;

endmodule

// File: tb/tb_gates_bist.sv
// tb_gates_bist
// Two sequencers (HOLD_CYCLES=4 and HOLD_CYCLES=1) each drive a behavioural
// Gates block whose AND/OR/NOT outputs can be faulted (good, stuck-0,
// stuck-1, inverted). The driver computes each run's expected summary from
// the truth table and queues it; a monitor pops it when done rises and also
// follows the A/B stepping cycle by cycle. The two DUTs are exercised one at
// a time so a single scoreboard queue serves both.
module tb_gates_bist;
  import gates_bist_pkg::*;

  typedef struct {
    int         dut;
    logic       pass;
    logic [2:0] err;
    logic [3:0] fvec;
  } exp_t;

  // Fault modes for the behavioural Gates block.
  localparam int M_GOOD = 0, M_S0 = 1, M_S1 = 2, M_INV = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst   [2];
  logic start [2];
  int   mode_and, mode_or, mode_not;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   passed = 0;
  int   total  = 0;

  exp_t sb[$];
  logic run_live  = 1'b0;
  int   run_dut   = 0;
  int   run_start = 0;

  gates_bist_if bif0 ();
  gates_bist_if bif1 ();

  gates_bist #(.HOLD_CYCLES(4)) dut0 (.clk(clk), .rst(rst[0]), .bus(bif0.master));
  gates_bist #(.HOLD_CYCLES(1)) dut1 (.clk(clk), .rst(rst[1]), .bus(bif1.master));

  function automatic logic gate_out(input int mode, input logic good);
    case (mode)
      M_S0:    return 1'b0;
      M_S1:    return 1'b1;
      M_INV:   return ~good;
      default: return good;
    endcase
  endfunction

  assign bif0.start  = start[0];
  assign bif0.AND_in = gate_out(mode_and, bif0.A & bif0.B);
  assign bif0.OR_in  = gate_out(mode_or,  bif0.A | bif0.B);
  assign bif0.NOT_in = gate_out(mode_not, ~bif0.A);
  assign bif1.start  = start[1];
  assign bif1.AND_in = gate_out(mode_and, bif1.A & bif1.B);
  assign bif1.OR_in  = gate_out(mode_or,  bif1.A | bif1.B);
  assign bif1.NOT_in = gate_out(mode_not, ~bif1.A);

  logic       done_w [2], busy_w [2], pass_w [2], a_w [2], b_w [2];
  logic [2:0] err_w  [2];
  logic [3:0] fv_w   [2];
  assign done_w[0] = bif0.done;      assign done_w[1] = bif1.done;
  assign busy_w[0] = bif0.busy;      assign busy_w[1] = bif1.busy;
  assign pass_w[0] = bif0.pass;      assign pass_w[1] = bif1.pass;
  assign a_w[0]    = bif0.A;         assign a_w[1]    = bif1.A;
  assign b_w[0]    = bif0.B;         assign b_w[1]    = bif1.B;
  assign err_w[0]  = bif0.err_count; assign err_w[1]  = bif1.err_count;
  assign fv_w[0]   = bif0.fail_vec;  assign fv_w[1]   = bif1.fail_vec;

  function automatic int hold_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  // Expected run summary straight from the truth table and the fault modes.
  function automatic exp_t model(input int d);
    exp_t e;
    int   a, b, g_and, g_or, g_not;
    e.dut  = d;
    e.err  = '0;
    e.fvec = '0;
    for (int v = 0; v < 4; v++) begin
      a     = (v >> 1) & 1;
      b     = v & 1;
      g_and = int'(gate_out(mode_and, logic'(a & b)));
      g_or  = int'(gate_out(mode_or,  logic'(a | b)));
      g_not = int'(gate_out(mode_not, logic'(1 - a)));
      if (g_and != (a & b) || g_or != (a | b) || g_not != (1 - a)) begin
        e.fvec[v] = 1'b1;
        e.err     = e.err + 3'd1;
      end
    end
    e.pass = (e.err == 3'd0);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: A/B stepping during a run, full summary when done rises.
  initial begin : monitor
    logic [1:0] dprev;
    exp_t       e;
    int         k, h, idx;
    dprev = '0;
    forever begin
      @(negedge clk);
      if (run_live) begin
        h = hold_of(run_dut);
        k = cyc - run_start;
        if (k >= 0 && k <= 4 * h) begin
          idx = k / h;
          if (idx > 3) idx = 3;
          check("ab_step", {30'd0, a_w[run_dut], b_w[run_dut]}, 32'(idx));
        end
      end
      for (int d = 0; d < 2; d++) begin
        if (done_w[d] === 1'b1 && dprev[d] !== 1'b1) begin
          if (sb.size() == 0) begin
            total++;
            $display("FAIL done_without_run: dut%0d raised done with nothing queued", d);
          end else begin
            e = sb.pop_front();
            check("done_dut",     32'(d), 32'(e.dut));
            check("done_latency", 32'(cyc - run_start), 32'(4 * hold_of(d)));
            check("done_busy",    {31'd0, busy_w[d]}, 32'd0);
            check("pass",         {31'd0, pass_w[d]}, {31'd0, e.pass});
            check("err_count",    {29'd0, err_w[d]},  {29'd0, e.err});
            check("fail_vec",     {28'd0, fv_w[d]},   {28'd0, e.fvec});
            run_live = 1'b0;
          end
        end
        dprev[d] = done_w[d];
      end
    end
  end

  task automatic do_reset(input int d, input logic with_start);
    @(negedge clk);
    run_live = 1'b0;
    sb.delete();
    rst[d]   = 1'b1;
    start[d] = with_start;
    @(posedge clk);
    @(negedge clk);
    rst[d]   = 1'b0;
    start[d] = 1'b0;
    check("rst_busy", {31'd0, busy_w[d]}, 32'd0);
    check("rst_done", {31'd0, done_w[d]}, 32'd0);
    check("rst_pass", {31'd0, pass_w[d]}, 32'd0);
    check("rst_ab",   {30'd0, a_w[d], b_w[d]}, 32'd0);
    check("rst_err",  {29'd0, err_w[d]}, 32'd0);
    check("rst_fvec", {28'd0, fv_w[d]},  32'd0);
  endtask

  task automatic start_run(input int d);
    @(negedge clk);
    sb.push_back(model(d));
    run_dut   = d;
    run_start = cyc + 1;
    run_live  = 1'b1;
    start[d]  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[d] = 1'b0;
    check("start_busy",     {31'd0, busy_w[d]}, 32'd1);
    check("start_done_clr", {31'd0, done_w[d]}, 32'd0);
    check("start_err_clr",  {29'd0, err_w[d]},  32'd0);
    check("start_fvec_clr", {28'd0, fv_w[d]},   32'd0);
  endtask

  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    for (int i = 0; i < 4 * hold_of(d) + 8 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("run_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
      run_live = 1'b0;
    end
    // DONE must hold steady with the last vector applied.
    repeat (3) @(negedge clk);
    check("done_hold", {31'd0, done_w[d]}, 32'd1);
    check("done_ab",   {30'd0, a_w[d], b_w[d]}, 32'd3);
  endtask

  task automatic set_modes(input int ma, input int mo, input int mn);
    mode_and = ma;
    mode_or  = mo;
    mode_not = mn;
  endtask

  initial begin
    rst[0] = 1'b1; rst[1] = 1'b1;
    start[0] = 1'b0; start[1] = 1'b0;
    set_modes(M_GOOD, M_GOOD, M_GOOD);
    do_reset(0, 1'b0);
    do_reset(1, 1'b0);

    // Known-good Gates.
    start_run(0); wait_done(0);
    // NOT stuck at 0: vectors 0 and 1 fail.
    set_modes(M_GOOD, M_GOOD, M_S0);
    start_run(0); wait_done(0);
    // AND stuck at 1: vectors 0..2 fail; then OR stuck at 0: vectors 1..3 fail.
    set_modes(M_S1, M_GOOD, M_GOOD);
    start_run(0); wait_done(0);
    set_modes(M_GOOD, M_S0, M_GOOD);
    start_run(0); wait_done(0);
    // start re-pulsed while at idx2 must not restart or stretch the run.
    set_modes(M_GOOD, M_GOOD, M_GOOD);
    start_run(0);
    repeat (2 * hold_of(0)) @(negedge clk);
    pulse_start(0);
    wait_done(0);
    // Reset mid-run at idx2, together with start: reset wins.
    start_run(0);
    repeat (2 * hold_of(0)) @(negedge clk);
    do_reset(0, 1'b1);
    start_run(0); wait_done(0);
    // Failing run, then restart straight from DONE with good Gates.
    set_modes(M_GOOD, M_GOOD, M_S0);
    start_run(0); wait_done(0);
    set_modes(M_GOOD, M_GOOD, M_GOOD);
    start_run(0); wait_done(0);
    // Same on the HOLD_CYCLES=1 instance.
    set_modes(M_GOOD, M_GOOD, M_S0);
    start_run(1); wait_done(1);
    set_modes(M_GOOD, M_GOOD, M_GOOD);
    start_run(1); wait_done(1);

    // Randomised fault patterns on either instance.
    for (int r = 0; r < 24; r++) begin
      int d;
      d = int'($urandom_range(0, 1));
      set_modes(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
      start_run(d);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 2 * hold_of(d))) @(negedge clk);
        pulse_start(d);
      end
      wait_done(d);
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
